// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for DIV/DIVU in the execute stage.
// One quotient bit per cycle on operand magnitudes, sign correction on exit.
// The result is held while start_i stays high and cleared when it drops.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    // {partial remainder, dividend/quotient bits}; a final shift exposes the
    // 2W+1-bit working value whose top W+1 bits feed the trial subtraction.
    logic [2*WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0]   divisor_reg;
    logic               neg_quot_reg;
    logic               neg_rem_reg;

    logic [2*WIDTH:0]   shifted;
    logic [WIDTH:0]     trial_diff;
    logic [2*WIDTH-1:0] shift_next;
    logic [WIDTH-1:0]   dividend_mag;
    logic [WIDTH-1:0]   divisor_mag;
    logic [WIDTH-1:0]   quot_raw;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    // One restoring step plus operand magnitudes and final sign correction.
    // The remainder is always below the divisor, so after the shift the
    // upper part is below twice the divisor and a W+1-bit difference cannot
    // wrap: its top bit is a reliable "negative" flag.
    always_comb begin
        shifted    = {shift_reg, 1'b0};
        trial_diff = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_reg};
        if (trial_diff[WIDTH]) begin
            shift_next = shifted[2*WIDTH-1:0];
        end else begin
            shift_next = {trial_diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
        end

        dividend_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
        divisor_mag  = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

        quot_raw   = shift_reg[WIDTH-1:0];
        rem_raw    = shift_reg[2*WIDTH-1:WIDTH];
        quot_fixed = neg_quot_reg ? (~quot_raw + 1'b1) : quot_raw;
        rem_fixed  = neg_rem_reg  ? (~rem_raw + 1'b1)  : rem_raw;
    end

    // Control FSM with registered ready/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            shift_reg    <= '0;
            divisor_reg  <= '0;
            neg_quot_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            ready_o      <= 1'b0;
            result_o     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state_reg <= BYZERO;
                        end else begin
                            state_reg    <= ON;
                            cnt_reg      <= '0;
                            shift_reg    <= {{WIDTH{1'b0}}, dividend_mag};
                            divisor_reg  <= divisor_mag;
                            neg_quot_reg <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            neg_rem_reg  <= signed_div_i && opdata1_i[WIDTH-1];
                        end
                    end
                end
                BYZERO: begin
                    state_reg <= END;
                    ready_o   <= 1'b1;
                    result_o  <= '0;
                end
                ON: begin
                    if (annul_i) begin
                        state_reg <= IDLE;
                        ready_o   <= 1'b0;
                        result_o  <= '0;
                    end else if (cnt_reg == CNT_W'(WIDTH)) begin
                        state_reg <= END;
                        ready_o   <= 1'b1;
                        result_o  <= {rem_fixed, quot_fixed};
                    end else begin
                        shift_reg <= shift_next;
                        cnt_reg   <= cnt_reg + 1'b1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        state_reg <= IDLE;
                        ready_o   <= 1'b0;
                        result_o  <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_o   <= 1'b0;
                    result_o  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. EX issues a start request with two operands, holds it, and stalls the pipeline until `ready_o` rises. Then it takes the 64-bit `{remainder, quotient}` result for the HI/LO write and drops `start_i`. A branch or exception flush cancels a division in flight through `annul_i`.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  division request; held high by EX until ready_o is seen.
- annul_i  in  1  cancel current/requested division.
- result_o  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; valid only while ready_o=1, else 0.
- ready_o  out  1  result valid.

## Operation
- Four states: IDLE, BYZERO, ON, END. Registered outputs.
- Reset, at any time and in any state: state=IDLE, ready_o=0, result_o=0, cnt=0.
- IDLE:
  - start_i=1, annul_i=0, divisor=0 -> BYZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON. cnt=0. Operands are latched.
  - Signed mode latches the magnitudes of negative operands (two's-complement negate); unsigned mode latches operands as-is.
  - The operand signs and the mode are also latched. Later changes on opdata*/signed_div_i are ignored.
  - start_i=1 with annul_i=1 is ignored; the state stays IDLE.
- BYZERO: next edge -> END with result_o=0.
- ON, restoring shift-subtract, one quotient bit per cycle:
  - Partial remainder is a (W+1)-bit trial subtraction of the latched divisor from the upper part of a 2W+1-bit shift register.
  - Non-negative difference: shift in 1 and replace the upper part. Negative difference: shift in 0.
  - cnt increments each iteration.
  - cnt==WIDTH -> END. Sign-correct the quotient: negate if signed and the operand signs differ. Sign-correct the remainder: negate if signed and the dividend was negative.
  - Load result_o and set ready_o=1.
  - annul_i=1 in any ON cycle -> IDLE next edge. No result; ready_o stays 0.
- END: ready_o=1 and result_o are held while start_i=1. When start_i=0 -> IDLE with ready_o=0 and result_o=0. annul_i is ignored in END.
- Wrap: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. No overflow flag.
- Remainder sign follows the dividend, per MIPS.

## Timing
- E0 is the edge that samples start_i in IDLE.
- Nonzero divisor:
  - E1..E32 perform the 32 iterations.
  - E33 enters END; ready_o is high after E33, i.e. for the cycle after 33 edges past E0.
  - Total latency from start_i rising is 34 edges.
- Zero divisor: E1 -> END, so ready_o is high after E1.
- Release: the first edge sampling start_i=0 in END returns to IDLE. A new start can be accepted on the next edge. Back-to-back results are therefore at least 1 idle cycle apart.
- Annul: the edge sampling annul_i=1 in ON returns to IDLE. A start_i sampled on the following edge starts fresh.
- Simultaneous rst and start_i: rst wins.

## Test plan
- Unsigned 100 / 7: hold start -> ready_o rises after E33, result_o=0x00000002_0000000E. Drop start -> ready_o=0 and result_o=0 next edge.
- Signed 0xFFFFFFF9 (-7) / 2 -> result_o=0xFFFFFFFF_FFFFFFFD. The same operands unsigned -> quotient 0x7FFFFFFC, remainder 1.
- Divide by zero, 5 / 0 (either mode) -> ready_o after E1, result_o=0.
- Annul at E10 mid-division -> IDLE, ready_o never asserts. A following unsigned 0xFFFFFFFF / 0x10 -> result_o=0x0000000F_0FFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF -> result_o=0x00000000_80000000. Change opdata during ON -> result unchanged.
- rst at E20 of a division -> ready_o=0 and result_o=0 after that edge. A new start then completes normally with full latency.
